mcdt_arbiter: RTL

Output-side arbiter for the mcdt multi-channel data transfer block. It shares the single mcdt output port between three channel slave FIFOs and pops words from the granted FIFO in bursts. Selection is by per-channel priority, with round-robin tie-break and a per-channel enable. Sits between the three channel FIFOs and the mcdt_data_o/mcdt_val_o/mcdt_id_o formatter outputs.

---
 rtl/mcdt_arbiter.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/mcdt_arbiter.sv
// mcdt_arbiter: output-side arbiter for the mcdt multi-channel data transfer block.
// Three channel FIFOs share one output port. The winner is the highest-priority
// eligible channel, and ties are broken round-robin. The granted FIFO is then
// popped in bursts of up to BURST_LEN words.
// Optional feature: define MCDT_ARB_STATS_EN to add per-channel grant counters
// (chN_gnt_cnt_o) and the stats_clr_i input.
module mcdt_arbiter #(
  parameter int unsigned DW        = 32,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ch0_req_i,
  input  logic [DW-1:0]     ch0_data_i,
  input  logic              ch0_en_i,
  input  logic [1:0]        ch0_prio_i,
  output logic              ch0_ack_o,
  input  logic              ch1_req_i,
  input  logic [DW-1:0]     ch1_data_i,
  input  logic              ch1_en_i,
  input  logic [1:0]        ch1_prio_i,
  output logic              ch1_ack_o,
  input  logic              ch2_req_i,
  input  logic [DW-1:0]     ch2_data_i,
  input  logic              ch2_en_i,
  input  logic [1:0]        ch2_prio_i,
  output logic              ch2_ack_o,
  output logic [DW-1:0]     mcdt_data_o,
  output logic              mcdt_val_o,
  output logic [1:0]        mcdt_id_o,
  output logic              busy_o
`ifdef MCDT_ARB_STATS_EN
  ,
  input  logic              stats_clr_i,
  output logic [CNT_W-1:0]  ch0_gnt_cnt_o,
  output logic [CNT_W-1:0]  ch1_gnt_cnt_o,
  output logic [CNT_W-1:0]  ch2_gnt_cnt_o
`endif
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  // Burst counter wide enough for BURST_LEN up to 16
  localparam int unsigned   BCW      = 5;
  localparam logic [BCW-1:0] CNT_LAST = BCW'(BURST_LEN - 1);

  // Elaboration-time parameter sanity check
  if (BURST_LEN < 1 || BURST_LEN > 16 || CNT_W < 1) begin : g_param_check
    $error("mcdt_arbiter: illegal BURST_LEN or CNT_W");
  end

  logic [2:0]    req_v;
  logic [2:0]    en_v;
  logic [2:0]    elig;
  logic [1:0]    prio_v [3];
  logic [DW-1:0] data_v [3];

  assign req_v     = {ch2_req_i, ch1_req_i, ch0_req_i};
  assign en_v      = {ch2_en_i, ch1_en_i, ch0_en_i};
  assign elig      = req_v & en_v;
  assign prio_v[0] = ch0_prio_i;
  assign prio_v[1] = ch1_prio_i;
  assign prio_v[2] = ch2_prio_i;
  assign data_v[0] = ch0_data_i;
  assign data_v[1] = ch1_data_i;
  assign data_v[2] = ch2_data_i;

  logic [0:0]     state_q, state_d;
  logic [1:0]     cur_id_q, cur_id_d;
  logic [1:0]     last_id_q, last_id_d;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic [DW-1:0]  data_q, data_d;
  logic           val_q, val_d;
  logic [1:0]     id_q, id_d;

  logic [2:0]     ack_c;
  logic [1:0]     win_id;
  logic           win_vld;
  logic [1:0]     max_prio;
  logic [2:0]     cand;
  logic [1:0]     rr_idx;
  logic           cur_elig;
  logic [DW-1:0]  cur_data;

  // (base + step) mod 3 for base in 0..2, step in 1..3
  function automatic logic [1:0] rr_step(input logic [1:0] base, input logic [1:0] step);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, step};
    if (sum >= 3'd3) sum = sum - 3'd3;
    if (sum >= 3'd3) sum = sum - 3'd3;
    return sum[1:0];
  endfunction

  // Winner: highest priority among eligible, round-robin from last_id+1 on ties
  always_comb begin
    max_prio = '0;
    cand     = '0;
    rr_idx   = '0;
    win_id   = '0;
    win_vld  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (elig[i] && (prio_v[i] > max_prio)) max_prio = prio_v[i];
    end
    for (int i = 0; i < 3; i++) begin
      cand[i] = elig[i] && (prio_v[i] == max_prio);
    end
    for (int k = 1; k <= 3; k++) begin
      rr_idx = rr_step(last_id_q, 2'(k));
      for (int i = 0; i < 3; i++) begin
        if (!win_vld && cand[i] && (rr_idx == 2'(i))) begin
          win_id  = rr_idx;
          win_vld = 1'b1;
        end
      end
    end
  end

  // View of the currently granted channel
  always_comb begin
    cur_elig = 1'b0;
    cur_data = '0;
    for (int i = 0; i < 3; i++) begin
      if (cur_id_q == 2'(i)) begin
        cur_elig = elig[i];
        cur_data = data_v[i];
      end
    end
  end

  // Next-state, pop strobes and output-word capture
  always_comb begin
    state_d   = state_q;
    cur_id_d  = cur_id_q;
    last_id_d = last_id_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    val_d     = 1'b0;
    id_d      = id_q;
    ack_c     = '0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d  = S_BURST;
          cur_id_d = win_id;
          cnt_d    = '0;
        end
      end
      S_BURST: begin
        if (cur_elig) begin
          for (int i = 0; i < 3; i++) begin
            ack_c[i] = (cur_id_q == 2'(i));
          end
          val_d  = 1'b1;
          data_d = cur_data;
          id_d   = cur_id_q;
          cnt_d  = cnt_q + BCW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d   = S_IDLE;
            last_id_d = cur_id_q;
          end
        end else begin
          state_d   = S_IDLE;
          last_id_d = cur_id_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cur_id_q  <= 2'd0;
      last_id_q <= 2'd2;
      cnt_q     <= '0;
      data_q    <= '0;
      val_q     <= 1'b0;
      id_q      <= 2'd0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      last_id_q <= last_id_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      val_q     <= val_d;
      id_q      <= id_d;
    end
  end

  assign ch0_ack_o   = ack_c[0];
  assign ch1_ack_o   = ack_c[1];
  assign ch2_ack_o   = ack_c[2];
  assign mcdt_data_o = data_q;
  assign mcdt_val_o  = val_q;
  assign mcdt_id_o   = id_q;
  assign busy_o      = (state_q == S_BURST);

  // At most one FIFO is popped per cycle
  a_ack_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ack_c));

`ifdef MCDT_ARB_STATS_EN
  logic             grant_c;
  logic [CNT_W-1:0] gnt_cnt_q [3];

  assign grant_c = (state_q == S_IDLE) && win_vld;

  // Saturating per-channel grant counters; clear has precedence over increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 3; i++) gnt_cnt_q[i] <= '0;
    end else if (stats_clr_i) begin
      for (int i = 0; i < 3; i++) gnt_cnt_q[i] <= '0;
    end else if (grant_c) begin
      for (int i = 0; i < 3; i++) begin
        if ((win_id == 2'(i)) && (gnt_cnt_q[i] != '1)) begin
          gnt_cnt_q[i] <= gnt_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign ch0_gnt_cnt_o = gnt_cnt_q[0];
  assign ch1_gnt_cnt_o = gnt_cnt_q[1];
  assign ch2_gnt_cnt_o = gnt_cnt_q[2];
`endif

endmodule
